// File: rtl/nios2_oci_dct_packer.sv
// DCT trace-code packer: 2-bit codes into SLOTS-slot frames,
// one output register drained over a valid/ready handshake.
//
// Ports:
//   clk, reset_n          clock, async active-low reset
//   trc_on                trace enable, falling edge flushes
//   code_valid, code      incoming 2-bit DCT code
//   flush_req             close the current partial frame
//   frame_valid/ready     output handshake
//   frame_data/count      packed frame and its slot count
//   dct_buffer/count      live accumulator view
//   overflow, drop_count  dropped-code pulse and counter
module nios2_oci_dct_packer #(
  parameter int SLOTS  = 15,
  parameter int DROP_W = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 trc_on,
  input  logic                 code_valid,
  input  logic [1:0]           code,
  input  logic                 flush_req,
  output logic                 frame_valid,
  input  logic                 frame_ready,
  output logic [2*SLOTS-1:0]   frame_data,
  output logic [$clog2(SLOTS+1)-1:0] frame_count,
  output logic [2*SLOTS-1:0]   dct_buffer,
  output logic [$clog2(SLOTS+1)-1:0] dct_count,
  output logic                 overflow,
  output logic [DROP_W-1:0]    drop_count
);

  localparam int FW = 2 * SLOTS;
  localparam int CW = $clog2(SLOTS + 1);

  typedef enum logic {
    FILL,
    STALL
  } state_t;

  state_t        state;
  logic          trc_on_q;
  logic          acc_code;
  logic          flush;
  logic          out_free;
  logic          full;
  logic          close;
  logic [FW-1:0] app_buf;
  logic [CW-1:0] app_cnt;
  logic [DROP_W-1:0] drop_nxt;

  assign acc_code = trc_on && code_valid;
  assign flush    = flush_req
                 || (trc_on_q && !trc_on);
  assign out_free = !frame_valid
                 || frame_ready;

  // accumulator contents including this
  // cycle's code, if any
  always_comb begin
    app_buf = dct_buffer;
    app_cnt = dct_count;
    for (int i = 0; i < SLOTS; i++) begin
      if (acc_code && dct_count == CW'(i))
        app_buf[2*i +: 2] = code;
    end
    if (acc_code)
      app_cnt = dct_count + CW'(1);
  end

  assign full  = (app_cnt == CW'(SLOTS));
  assign close = full
              || (flush && app_cnt != '0);

  assign drop_nxt = (drop_count == '1)
                  ? drop_count
                  : drop_count + DROP_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= FILL;
      trc_on_q    <= 1'b0;
      frame_valid <= 1'b0;
      frame_data  <= '0;
      frame_count <= '0;
      dct_buffer  <= '0;
      dct_count   <= '0;
      overflow    <= 1'b0;
      drop_count  <= '0;
    end else begin
      trc_on_q <= trc_on;
      overflow <= 1'b0;
      unique case (state)
        FILL: begin
          if (close && out_free) begin
            frame_data  <= app_buf;
            frame_count <= app_cnt;
            frame_valid <= 1'b1;
            dct_buffer  <= '0;
            dct_count   <= '0;
          end else begin
            dct_buffer <= app_buf;
            dct_count  <= app_cnt;
            if (close)
              state <= STALL;
            else if (frame_ready)
              frame_valid <= 1'b0;
          end
        end
        STALL: begin
          // closed frame waits in the
          // accumulator; new codes are lost
          if (acc_code) begin
            overflow   <= 1'b1;
            drop_count <= drop_nxt;
          end
          if (out_free) begin
            frame_data  <= dct_buffer;
            frame_count <= dct_count;
            frame_valid <= 1'b1;
            dct_buffer  <= '0;
            dct_count   <= '0;
            state       <= FILL;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nios2_oci_dct_packer.sv
// Scoreboard bench for nios2_oci_dct_packer:
// queue-based reference model, negedge monitor.
module tb_nios2_oci_dct_packer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        trc_on = 1'b0;
  logic        code_valid = 1'b0;
  logic [1:0]  code = 2'd0;
  logic        flush_req = 1'b0;
  logic        frame_ready = 1'b0;
  logic        frame_valid;
  logic [29:0] frame_data;
  logic [3:0]  frame_count;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        overflow;
  logic [7:0]  drop_count;

  nios2_oci_dct_packer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .trc_on      (trc_on),
    .code_valid  (code_valid),
    .code        (code),
    .flush_req   (flush_req),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_data  (frame_data),
    .frame_count (frame_count),
    .dct_buffer  (dct_buffer),
    .dct_count   (dct_count),
    .overflow    (overflow),
    .drop_count  (drop_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [29:0] d;
    logic [3:0]  n;
  } frm_t;

  frm_t       sb[$];
  frm_t       mon_f;
  logic [1:0] m_q[$];
  bit         m_valid;
  bit         m_stall;
  bit         m_ovf;
  bit         m_prev;
  int         m_drops;

  task automatic chk(string nm,
                     longint act,
                     longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [29:0] m_pack();
    logic [29:0] r = '0;
    foreach (m_q[k])
      r = r | (30'(m_q[k]) << (2 * k));
    return r;
  endfunction

  task automatic m_reset();
    m_q.delete();
    sb.delete();
    m_valid = 0;
    m_stall = 0;
    m_ovf   = 0;
    m_prev  = 0;
    m_drops = 0;
  endtask

  task automatic m_emit();
    frm_t f;
    f.d = m_pack();
    f.n = 4'(m_q.size());
    sb.push_back(f);
    m_q.delete();
    m_valid = 1;
  endtask

  // predicts the state after the next edge
  task automatic m_step();
    bit acc;
    bit fl;
    bit ofree;
    bit cl;
    acc   = trc_on && code_valid;
    fl    = flush_req || (m_prev && !trc_on);
    ofree = !m_valid || frame_ready;
    m_ovf = 0;
    if (!m_stall) begin
      if (acc)
        m_q.push_back(code);
      cl = (m_q.size() == 15)
        || (fl && m_q.size() > 0);
      if (cl && ofree)
        m_emit();
      else if (cl)
        m_stall = 1;
      else if (frame_ready)
        m_valid = 0;
    end else begin
      if (acc) begin
        m_ovf = 1;
        if (m_drops < 255)
          m_drops++;
      end
      if (ofree) begin
        m_emit();
        m_stall = 0;
      end
    end
    m_prev = trc_on;
  endtask

  task automatic cyc(bit t, bit cv,
                     logic [1:0] c,
                     bit f, bit r);
    trc_on      = t;
    code_valid  = cv;
    code        = c;
    flush_req   = f;
    frame_ready = r;
    m_step();
    @(posedge clk);
    #1;
    chk("dct_count", dct_count, m_q.size());
    chk("dct_buffer", dct_buffer, m_pack());
    chk("frame_valid", frame_valid, m_valid);
    chk("overflow", overflow, m_ovf);
    chk("drop_count", drop_count, m_drops);
    if (m_valid && sb.size() > 0) begin
      chk("hold_data", frame_data, sb[0].d);
      chk("hold_count", frame_count, sb[0].n);
    end
  endtask

  task automatic idle(int n, bit r);
    for (int i = 0; i < n; i++)
      cyc(1, 0, 2'd0, 0, r);
  endtask

  always @(negedge clk) begin
    if (reset_n && frame_valid
        && frame_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_empty act=%0h exp=none",
                 frame_data);
      end else begin
        mon_f = sb.pop_front();
        chk("frame_data", frame_data, mon_f.d);
        chk("frame_count", frame_count, mon_f.n);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout act=running exp=done");
    $fatal(1);
  end

  initial begin
    m_reset();
    #1;
    chk("rst_valid", frame_valid, 0);
    chk("rst_data", frame_data, 0);
    chk("rst_count", frame_count, 0);
    chk("rst_buf", dct_buffer, 0);
    chk("rst_dcnt", dct_count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_drop", drop_count, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // T1: full frame, immediate output
    idle(2, 1);
    for (int i = 0; i < 15; i++)
      cyc(1, 1, 2'(i % 4), 0, 1);
    chk("t1_valid", frame_valid, 1);
    chk("t1_count", frame_count, 15);
    chk("t1_dcnt", dct_count, 0);
    idle(3, 1);

    // T2: partial flush, then empty flush
    cyc(1, 1, 2'd3, 0, 1);
    cyc(1, 1, 2'd2, 0, 1);
    cyc(1, 1, 2'd1, 0, 1);
    cyc(1, 0, 2'd0, 1, 1);
    chk("t2_data", frame_data, 30'h1B);
    chk("t2_count", frame_count, 3);
    idle(2, 1);
    cyc(1, 0, 2'd0, 1, 1);
    chk("t2_noframe", frame_valid, 0);
    idle(2, 1);

    // T3: stall with drops, then drain
    for (int i = 0; i < 35; i++)
      cyc(1, 1, 2'($urandom_range(0, 3)), 0, 0);
    chk("t3_drops", drop_count, 5);
    idle(3, 0);
    idle(5, 1);

    // T4: code with flush at count 4
    for (int i = 0; i < 4; i++)
      cyc(1, 1, 2'd1, 0, 1);
    cyc(1, 1, 2'd2, 1, 1);
    chk("t4_count", frame_count, 5);
    chk("t4_slot4", frame_data[9:8], 2);
    idle(3, 1);

    // T5: drop counter saturation
    for (int i = 0; i < 330; i++)
      cyc(1, 1, 2'($urandom_range(0, 3)), 0, 0);
    chk("t5_sat", drop_count, 255);
    idle(5, 1);

    // T6: async reset mid-frame
    for (int i = 0; i < 22; i++)
      cyc(1, 1, 2'($urandom_range(0, 3)), 0, 0);
    #2;
    reset_n = 1'b0;
    #1;
    m_reset();
    chk("t6_valid", frame_valid, 0);
    chk("t6_data", frame_data, 0);
    chk("t6_buf", dct_buffer, 0);
    chk("t6_dcnt", dct_count, 0);
    chk("t6_drop", drop_count, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc(1, 0, 2'd0, 0, 1);
    cyc(1, 1, 2'd2, 0, 1);
    cyc(1, 1, 2'd3, 0, 1);
    cyc(0, 0, 2'd0, 0, 1);
    chk("t6_fcount", frame_count, 2);
    idle(3, 1);

    // randomized traffic
    for (int i = 0; i < 1500; i++)
      cyc($urandom_range(0, 19) != 0,
          $urandom_range(0, 2) != 0,
          2'($urandom_range(0, 3)),
          $urandom_range(0, 9) == 0,
          $urandom_range(0, 3) != 0);
    idle(20, 1);
    chk("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
